ring_lookahead_route_stage: RTL

Parametrised, registered lookahead-routing stage for a bidirectional ring NoC. It sits between an input buffer and switch allocation. For each packet it computes the next-hop output direction from the head flit and holds that route for every body and tail flit of the packet. It supports any ring size, including non-power-of-two, a selectable shortest-path tie-break, and a valid/ready pipeline slice.

---
 rtl/ring_lookahead_route_stage.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ring_lookahead_route_stage.sv
// Lookahead route stage for a bidirectional ring NoC.
// Works out the next-hop direction from each head flit and holds that route
// for the rest of the packet, behind an optional registered valid/ready slice.
module ring_lookahead_route_stage #(
    parameter int RING_SIZE = 8,
    parameter int COORD_W   = (RING_SIZE > 1) ? $clog2(RING_SIZE) : 1,
    parameter int TIE_MODE  = 0,
    parameter int PIPE      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] position,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_head,
    input  logic               in_tail,
    input  logic [COORD_W-1:0] in_dest,
    input  logic [2:0]         in_routing,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_head,
    output logic               out_tail,
    output logic [2:0]         out_next_routing,
    output logic               err
);

    // One spare bit so that coordinate + RING_SIZE never overflows before wrapping.
    localparam int            DW    = COORD_W + 1;
    localparam logic [DW-1:0] RS_D  = DW'(RING_SIZE);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    localparam logic [2:0] DIR_W = 3'b001;
    localparam logic [2:0] DIR_E = 3'b010;
    localparam logic [2:0] DIR_L = 3'b100;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] position_q;
    logic [2:0]         route_q, route_d;
    logic               tog_q, tog_d;
    logic               err_q, err_d;

    logic               accept;
    logic               enc_ok;
    logic               dest_bad;
    logic               is_tie;
    logic               flit_err;
    logic [DW-1:0]      dest_x;
    logic [DW-1:0]      nx;
    logic [DW-1:0]      cw;
    logic [DW-1:0]      ccw;
    logic [2:0]         hop_route;
    logic [2:0]         flit_route;

    // Reduce a value in [0, 2*RING_SIZE) to [0, RING_SIZE); valid for any ring size.
    function automatic logic [DW-1:0] wrap_ring(input logic [DW-1:0] v);
        return (v >= RS_D) ? (v - RS_D) : v;
    endfunction

    // Direction chosen when both ways round are equally long.
    function automatic logic [2:0] tie_pick(input logic toggle);
        if (TIE_MODE == 0) begin
            return DIR_E;
        end else if (TIE_MODE == 1) begin
            return DIR_W;
        end else begin
            return toggle ? DIR_W : DIR_E;
        end
    endfunction

    // Hop distances from the next router to the destination, east and west, and the shortest-path pick.
    always_comb begin
        dest_x   = {1'b0, in_dest};
        dest_bad = (dest_x >= RS_D);
        if (in_routing == DIR_E) begin
            nx = wrap_ring({1'b0, position_q} + ONE_D);
        end else begin
            nx = wrap_ring({1'b0, position_q} + RS_D - ONE_D);
        end
        cw     = wrap_ring(dest_x + RS_D - nx);
        ccw    = wrap_ring(nx + RS_D - dest_x);
        is_tie = (cw == ccw) && (cw != '0);
        if (cw == '0) begin
            hop_route = DIR_L;
        end else if (cw < ccw) begin
            hop_route = DIR_E;
        end else if (ccw < cw) begin
            hop_route = DIR_W;
        end else begin
            hop_route = tie_pick(tog_q);
        end
    end

    // Route and error flag for the flit currently on the input, by flit type and packet state.
    always_comb begin
        enc_ok     = (in_routing == DIR_W) || (in_routing == DIR_E) || (in_routing == DIR_L);
        flit_route = route_q;
        flit_err   = 1'b0;
        if (in_head) begin
            if (!enc_ok) begin
                flit_route = in_routing;
            end else if ((in_routing == DIR_L) || dest_bad) begin
                flit_route = DIR_L;
            end else begin
                flit_route = hop_route;
            end
            flit_err = !enc_ok || dest_bad || (state_q == S_IN_PKT);
        end else begin
            if (!enc_ok) begin
                flit_route = in_routing;
            end
            flit_err = !enc_ok || (state_q == S_IDLE);
        end
    end

    // Packet tracking: only an accepted flit moves the FSM, the latched route or the tie toggle.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        tog_d   = tog_q;
        err_d   = accept && flit_err;
        if (accept) begin
            if (in_head) begin
                // A malformed head latches Local so the packet body cannot inherit a bad encoding.
                route_d = enc_ok ? flit_route : DIR_L;
                state_d = in_tail ? S_IDLE : S_IN_PKT;
                if (enc_ok && (in_routing != DIR_L) && !dest_bad && is_tie) begin
                    tog_d = ~tog_q;
                end
            end else if (in_tail) begin
                state_d = S_IDLE;
            end
        end
    end

    // Control registers: sampled position, packet FSM, latched route, tie toggle, error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            position_q <= '0;
            state_q    <= S_IDLE;
            route_q    <= DIR_L;
            tog_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            position_q <= position;
            state_q    <= state_d;
            route_q    <= route_d;
            tog_q      <= tog_d;
            err_q      <= err_d;
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic       out_valid_q, out_valid_d;
            logic       out_head_q, out_head_d;
            logic       out_tail_q, out_tail_d;
            logic [2:0] out_route_q, out_route_d;

            assign in_ready = !out_valid_q || out_ready;

            // Output slice: load on accept, clear valid once drained, otherwise hold stable.
            always_comb begin
                out_valid_d = out_valid_q;
                out_head_d  = out_head_q;
                out_tail_d  = out_tail_q;
                out_route_d = out_route_q;
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_head_d  = in_head;
                    out_tail_d  = in_tail;
                    out_route_d = flit_route;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end

            // Output slice registers; reset drops any in-flight flit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_q <= 1'b0;
                    out_head_q  <= 1'b0;
                    out_tail_q  <= 1'b0;
                    out_route_q <= DIR_L;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_head_q  <= out_head_d;
                    out_tail_q  <= out_tail_d;
                    out_route_q <= out_route_d;
                end
            end

            assign out_valid        = out_valid_q;
            assign out_head         = out_head_q;
            assign out_tail         = out_tail_q;
            assign out_next_routing = out_route_q;
        end else begin : g_bypass
            assign in_ready         = out_ready;
            assign out_valid        = in_valid;
            assign out_head         = in_head;
            assign out_tail         = in_tail;
            assign out_next_routing = flit_route;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign err    = err_q;

endmodule
